register_file_mp: RTL
=====================

Name: register_file_mp

Overview:
- Parametrised multi-port register file for the core pipeline.
- Next generation of the 2-read/1-write 32x32 file: configurable width, depth and port counts, optional hard-wired zero register.
- Adds synchronous reset of contents and a per-register scoreboard (busy bits) so issue logic can detect in-flight producers.
- Sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
DATA_WIDTH, 32, bits per register
NUM_REGS, 32, number of registers (>=2, need not be a power of two)
NUM_READ_PORTS, 2, combinational read ports
NUM_WRITE_PORTS, 2, writeback ports
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/reservations
(derived) AW = $clog2(NUM_REGS)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_read_number  input  NUM_READ_PORTS*AW  register index per read port, port p at [p*AW +: AW]
out_read_value  output  NUM_READ_PORTS*DATA_WIDTH  read data per port
out_read_pending  output  NUM_READ_PORTS  1 = register still awaiting its producer
in_write_enable  input  NUM_WRITE_PORTS  write strobe per port
in_write_number  input  NUM_WRITE_PORTS*AW  destination index per write port
in_write_value  input  NUM_WRITE_PORTS*DATA_WIDTH  write data per port
in_reserve_enable  input  1  mark one register busy (instruction issued)
in_reserve_number  input  AW  register to reserve
out_pending_count  output  AW+1  registered count of busy bits

Behaviour:
- Reset: one clock and one reset, as stated here. Reset is synchronous and active-low. While rst_n=0 at a rising clk edge, all registers go to 0, all busy bits to 0 and out_pending_count to 0. While rst_n=0, out_read_value=0 and out_read_pending=0 combinationally, and forwarding is suppressed.
- Write: on clk edge, memory[n] <= value for each enabled port with n < NUM_REGS (and n != 0 if ZERO_REG).
  - Same register on several enabled ports: highest-index port wins.
- Read (combinational, 0-cycle latency): value = memory[r], then forwarding.
  - Forwarding: if any enabled write port targets r this cycle, value = that port's data (highest index wins).
  - Override: r >= NUM_REGS, or (ZERO_REG and r == 0), gives value 0 and pending 0.
- Scoreboard:
  - Busy bit set on edge when in_reserve_enable (index valid, not zero reg).
  - Busy bit cleared on edge when any enabled write targets the register.
  - Reserve and write to the same register in the same cycle: reserve wins (bit stays/becomes 1; data still written).
  - out_read_pending = busy[r] & ~(write to r this cycle). A reservation is visible only from the next cycle.
  - Reserve of an already-busy register: no change.
  - Write to a non-busy register: data written, no scoreboard change.
- out_pending_count: registered. Next value = popcount of next busy vector; never exceeds NUM_REGS.
- Reset mid-operation: reset dominates reserve and write in the same cycle.

Decomposition:
- Package regfile_pkg: default DATA_WIDTH/NUM_REGS constants, helper function for the AW computation, and a typedef for a register index.
- One sub-module, regfile_scoreboard: busy vector, set/clear priority, pending count.
- Storage, forwarding and read muxing stay in register_file_mp.

Test Plan:
1. Reset: load r5=0xDEAD, hold rst_n=0 one edge -> read r5 = 0, pending 0, out_pending_count 0.
2. Dual write conflict: ports 0 and 1 both write r7 (0x11, 0x22) -> same-cycle read r7 = 0x22; next cycle memory r7 = 0x22.
3. Forwarding plus zero reg: write r0=0xFFFF and r3=0x1234 -> read r0 = 0 always; read r3 = 0x1234 in the same cycle and after.
4. Scoreboard:
   - Reserve r9 -> next cycle pending[r9]=1, count=1.
   - Write r9=0x55 -> pending=0 in that cycle, value 0x55; count=0 after the edge.
5. Simultaneous reserve and write of r4 -> r4 holds new data, pending=1 next cycle, count +1.
6. Out of range, with NUM_REGS=20, AW=5: read index 25 -> value 0, pending 0; write to index 25 is ignored and no register changes.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Keeps index-width derivation in one place so the file, bus and scoreboard agree.
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_REGS   = 32;

  // Index width for a given register count; a single-bit index is the floor.
  function automatic int calcAw(input int numRegs);
    return (numRegs > 1) ? $clog2(numRegs) : 1;
  endfunction

  typedef logic [calcAw(DEFAULT_NUM_REGS)-1:0] regIdx_t;

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle between issue/writeback logic (master) and the register file (slave).
// Port p of every packed field lives at [p*width +: width].
interface register_file_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS        = DEFAULT_NUM_REGS,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2
);
  localparam int AW = calcAw(NUM_REGS);

  logic [NUM_READ_PORTS*AW-1:0]          in_read_number;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  out_read_value;
  logic [NUM_READ_PORTS-1:0]             out_read_pending;
  logic [NUM_WRITE_PORTS-1:0]            in_write_enable;
  logic [NUM_WRITE_PORTS*AW-1:0]         in_write_number;
  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] in_write_value;
  logic                                  in_reserve_enable;
  logic [AW-1:0]                         in_reserve_number;
  logic [AW:0]                           out_pending_count;

  modport master (
    output in_read_number, in_write_enable, in_write_number, in_write_value,
           in_reserve_enable, in_reserve_number,
    input  out_read_value, out_read_pending, out_pending_count
  );

  modport slave (
    input  in_read_number, in_write_enable, in_write_number, in_write_value,
           in_reserve_enable, in_reserve_number,
    output out_read_value, out_read_pending, out_pending_count
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking an in-flight producer,
// plus a registered population count of the busy bits.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  localparam int AW = calcAw(NUM_REGS),
  localparam int CW = AW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REGS-1:0] set_i,
  input  logic [NUM_REGS-1:0] clear_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [CW-1:0]       count_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CW-1:0]       count_q, count_d;

  // Set is applied after clear so a same-cycle reservation survives the write.
  always_comb begin
    busy_d  = (busy_q & ~clear_i) | set_i;
    count_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      count_d = count_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o  = busy_q;
  assign count_o = count_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with write-to-read forwarding, optional hard-wired
// zero register and a busy-bit scoreboard for issue logic.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS        = DEFAULT_NUM_REGS,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int ZERO_REG        = 1
) (
  input logic clk,
  input logic rst_n,
  register_file_mp_if.slave rf
);

  localparam int AW = calcAw(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   writeHit;
  logic [NUM_REGS-1:0]   reserveSet;
  logic [NUM_REGS-1:0]   busy;
  logic [AW:0]           pendingCount;

  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] readValue;
  logic [NUM_READ_PORTS-1:0]            readPending;

  // Per-register write/reserve decode; later ports overwrite earlier ones so the
  // highest-index write port wins. Out-of-range and zero-register targets never match.
  always_comb begin
    writeHit   = '0;
    reserveSet = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (!(ZERO_REG != 0 && i == 0)) begin
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
          if (rf.in_write_enable[w] && rf.in_write_number[w*AW +: AW] == AW'(i)) begin
            writeHit[i] = 1'b1;
            regs_d[i]   = rf.in_write_value[w*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        reserveSet[i] = rf.in_reserve_enable && (rf.in_reserve_number == AW'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // regs_d already carries same-cycle write data, which gives forwarding for free.
  always_comb begin
    readValue   = '0;
    readPending = '0;
    if (rst_n) begin
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (rf.in_read_number[p*AW +: AW] == AW'(i) && !(ZERO_REG != 0 && i == 0)) begin
            readValue[p*DATA_WIDTH +: DATA_WIDTH] = regs_d[i];
            readPending[p] = busy[i] & ~writeHit[i];
          end
        end
      end
    end
  end

  regfile_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_i   (reserveSet),
    .clear_i (writeHit),
    .busy_o  (busy),
    .count_o (pendingCount)
  );

  assign rf.out_read_value    = readValue;
  assign rf.out_read_pending  = readPending;
  assign rf.out_pending_count = pendingCount;

endmodule
